// File: rtl/alu_share_ctrl.sv
// Two-requester controller that time-shares one external ALU: arbitrate, latch, settle, capture.
// Optional macro ALU_SHARE_RR_EN selects round-robin arbitration; otherwise req0 has fixed priority.
module alu_share_ctrl #(
  parameter int          LAT      = 1,
  parameter logic [3:0]  IDLE_GIN = 4'b1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  gin0,
  input  logic [3:0]  gin1,
  input  logic [1:0]  zc0,
  input  logic [1:0]  zc1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res,
  output logic        zout,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_gin,
  output logic [1:0]  alu_zcond,
  input  logic [31:0] alu_sum,
  input  logic        alu_zout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        owner_q;
  logic        gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [31:0] res_q;
  logic        zout_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_gin_q;
  logic [1:0]  alu_zcond_q;

  logic        any_req_d;
  logic        pick1_d;

`ifdef ALU_SHARE_RR_EN
  logic        last_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_req_d = req0 | req1;
    if (req0 && req1) begin
      pick1_d = (last_q == 1'b0);
    end else begin
      pick1_d = req1;
    end
  end
`else
  always_comb begin
    any_req_d = req0 | req1;
    pick1_d   = req1 & ~req0;
  end
`endif

  // The alu_* registers double as the operand latch while in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= 32'd0;
      zout_q      <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_gin_q   <= IDLE_GIN;
      alu_zcond_q <= 2'd0;
`ifdef ALU_SHARE_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            owner_q     <= pick1_d;
            gnt0_q      <= ~pick1_d;
            gnt1_q      <= pick1_d;
            alu_a_q     <= pick1_d ? a1   : a0;
            alu_b_q     <= pick1_d ? b1   : b0;
            alu_gin_q   <= pick1_d ? gin1 : gin0;
            alu_zcond_q <= pick1_d ? zc1  : zc0;
            cnt_q       <= CNT_INIT;
            busy_q      <= 1'b1;
            state_q     <= EXEC;
`ifdef ALU_SHARE_RR_EN
            last_q      <= pick1_d;
`endif
          end
        end
        EXEC: begin
          if (cnt_q == 2'd0) begin
            res_q       <= alu_sum;
            zout_q      <= alu_zout;
            done0_q     <= ~owner_q;
            done1_q     <= owner_q;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_gin_q   <= IDLE_GIN;
            alu_zcond_q <= 2'd0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign busy      = busy_q;
  assign res       = res_q;
  assign zout      = zout_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_gin   = alu_gin_q;
  assign alu_zcond = alu_zcond_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: instance 0 uses LAT=1, instance 1 uses LAT=3, each with a behavioural ALU.
// Arbitration expectations follow ALU_SHARE_RR_EN when it is defined for the build.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       req0, req1;
  logic [1:0][3:0]  gin0, gin1;
  logic [1:0][1:0]  zc0, zc1;
  logic [1:0][31:0] a0, b0, a1, b1;
  logic [1:0]       gnt0, gnt1, done0, done1, zout, busy, alu_zout;
  logic [1:0][31:0] res, alu_a, alu_b, alu_sum;
  logic [1:0][3:0]  alu_gin;
  logic [1:0][1:0]  alu_zcond;

  int tests = 0;
  int fails = 0;
  int exp_last [2];
  logic [31:0] exp_res [2];

  // Behavioural shared ALU: MIPS-like control codes, zero-condition select.
  function automatic logic [31:0] alu_ref(logic [3:0] g, logic [31:0] a, logic [31:0] b);
    case (g)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic z_ref(logic [1:0] zc, logic [31:0] s);
    case (zc)
      2'b00:   return (s == 32'd0);
      2'b01:   return (s != 32'd0);
      2'b10:   return s[31];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_share_ctrl #(.LAT(gi == 0 ? 1 : 3), .IDLE_GIN(4'b1000)) u_dut (
      .clk(clk), .reset(rst[gi]),
      .req0(req0[gi]), .req1(req1[gi]),
      .gin0(gin0[gi]), .gin1(gin1[gi]),
      .zc0(zc0[gi]), .zc1(zc1[gi]),
      .a0(a0[gi]), .b0(b0[gi]), .a1(a1[gi]), .b1(b1[gi]),
      .gnt0(gnt0[gi]), .gnt1(gnt1[gi]),
      .done0(done0[gi]), .done1(done1[gi]),
      .res(res[gi]), .zout(zout[gi]), .busy(busy[gi]),
      .alu_a(alu_a[gi]), .alu_b(alu_b[gi]),
      .alu_gin(alu_gin[gi]), .alu_zcond(alu_zcond[gi]),
      .alu_sum(alu_sum[gi]), .alu_zout(alu_zout[gi])
    );
    assign alu_sum[gi]  = alu_ref(alu_gin[gi], alu_a[gi], alu_b[gi]);
    assign alu_zout[gi] = z_ref(alu_zcond[gi], alu_sum[gi]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic set_fields(input int d, input int who, input logic [3:0] g, input logic [1:0] z,
                            input logic [31:0] a, input logic [31:0] b);
    if (who == 0) begin
      gin0[d] = g; zc0[d] = z; a0[d] = a; b0[d] = b;
    end else begin
      gin1[d] = g; zc1[d] = z; a1[d] = a; b1[d] = b;
    end
  endtask

  task automatic set_req(input int d, input int who, input logic v);
    if (who == 0) req0[d] = v;
    else          req1[d] = v;
  endtask

  // One request from an idle controller; checks grant, latency, latching and result.
  task automatic run_op(input int d, input int who, input logic [3:0] g, input logic [1:0] z,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ez;
    int          n;
    bit          seen;
    er = alu_ref(g, a, b);
    ez = z_ref(z, er);
    set_fields(d, who, g, z, a, b);
    set_req(d, who, 1'b1);
    tick();
    chk("gnt_own",   d, (who == 0) ? gnt0[d] : gnt1[d], 1);
    chk("gnt_other", d, (who == 0) ? gnt1[d] : gnt0[d], 0);
    set_req(d, who, 1'b0);
    set_fields(d, who, 4'($urandom), 2'($urandom), 32'd100, $urandom);
    exp_last[d] = who;
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      tick();
      n++;
      if (done0[d] | done1[d]) seen = 1;
      else chk("alu_a_latched", d, alu_a[d], a);
      if (n == 1) chk("gnt_width", d, gnt0[d] | gnt1[d], 0);
    end
    chk("done_latency", d, n, lat_of(d));
    chk("done_own",   d, (who == 0) ? done0[d] : done1[d], 1);
    chk("done_other", d, (who == 0) ? done1[d] : done0[d], 0);
    chk("res",  d, res[d], er);
    chk("zout", d, zout[d], ez);
    chk("busy_done", d, busy[d], 1);
    exp_res[d] = er;
    tick();
    chk("done_width",   d, done0[d] | done1[d], 0);
    chk("busy_idle",    d, busy[d], 0);
    chk("alu_gin_idle", d, alu_gin[d], 4'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  w;
    bit  bad_done, bad_gin, bad_busy, bad_res;
    rst = 2'b11; req0 = '0; req1 = '0;
    gin0 = '0; gin1 = '0; zc0 = '0; zc1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) tick();
    rst = 2'b00;
    for (int d = 0; d < 2; d++) begin
      exp_last[d] = 1;
      exp_res[d]  = 32'd0;
      chk("rst_gnt",   d, gnt0[d] | gnt1[d], 0);
      chk("rst_done",  d, done0[d] | done1[d], 0);
      chk("rst_busy",  d, busy[d], 0);
      chk("rst_res",   d, res[d], 0);
      chk("rst_zout",  d, zout[d], 0);
      chk("rst_gin",   d, alu_gin[d], 4'b1000);
      chk("rst_alu_a", d, alu_a[d], 0);
      chk("rst_zcond", d, alu_zcond[d], 0);
    end
    tick();

    // Directed operations, then randomized single-requester traffic.
    for (int d = 0; d < 2; d++) begin
      run_op(d, 0, 4'b0010, 2'b00, 32'd5, 32'd7);
      run_op(d, 1, 4'b0110, 2'b01, 32'd9, 32'd9);
      run_op(d, 0, 4'b0010, 2'b00, 32'd1, 32'd1);
      for (int i = 0; i < 20; i++) begin
        run_op(d, int'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), $urandom, $urandom);
      end
    end

    // Both requesters held high across four back-to-back operations.
    for (int d = 0; d < 2; d++) begin
      set_fields(d, 0, 4'b0010, 2'b00, 32'd10, 32'd20);
      set_fields(d, 1, 4'b0110, 2'b10, 32'd3,  32'd8);
      req0[d] = 1'b1;
      req1[d] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        n = 0;
        while (!(gnt0[d] | gnt1[d]) && n < 20) begin
          tick();
          n++;
        end
`ifdef ALU_SHARE_RR_EN
        w = (exp_last[d] == 0) ? 1 : 0;
`else
        w = 0;
`endif
        chk("arb_gnt0", d, gnt0[d], (w == 0));
        chk("arb_gnt1", d, gnt1[d], (w == 1));
        exp_last[d] = w;
        n = 0;
        while (!(done0[d] | done1[d]) && n < 10) begin
          tick();
          n++;
        end
        chk("arb_done", d, (w == 0) ? done0[d] : done1[d], 1);
        exp_res[d] = (w == 0) ? alu_ref(4'b0010, 32'd10, 32'd20) : alu_ref(4'b0110, 32'd3, 32'd8);
        chk("arb_res", d, res[d], exp_res[d]);
        if (k == 3) begin
          req0[d] = 1'b0;
          req1[d] = 1'b0;
        end
        tick();
      end
      tick();
    end

    // Quiet period: outputs idle and result held.
    for (int d = 0; d < 2; d++) begin
      bad_done = 0; bad_gin = 0; bad_busy = 0; bad_res = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (done0[d] | done1[d] | gnt0[d] | gnt1[d]) bad_done = 1;
        if (alu_gin[d] !== 4'b1000) bad_gin = 1;
        if (busy[d] !== 1'b0) bad_busy = 1;
        if (res[d] !== exp_res[d]) bad_res = 1;
      end
      chk("idle_pulses", d, bad_done, 0);
      chk("idle_gin",    d, bad_gin, 0);
      chk("idle_busy",   d, bad_busy, 0);
      chk("idle_res",    d, bad_res, 0);
      chk("idle_res_val", d, res[d], exp_res[d]);
    end

    // Reset one cycle into EXEC aborts the operation.
    for (int d = 0; d < 2; d++) begin
      set_fields(d, 0, 4'b0010, 2'b00, 32'd40, 32'd2);
      req0[d] = 1'b1;
      tick();
      chk("abort_gnt", d, gnt0[d], 1);
      req0[d] = 1'b0;
      rst[d]  = 1'b1;
      tick();
      rst[d]  = 1'b0;
      exp_last[d] = 1;
      exp_res[d]  = 32'd0;
      chk("abort_done", d, done0[d] | done1[d], 0);
      chk("abort_res",  d, res[d], 0);
      chk("abort_busy", d, busy[d], 0);
      chk("abort_gin",  d, alu_gin[d], 4'b1000);
      bad_done = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (done0[d] | done1[d]) bad_done = 1;
      end
      chk("abort_no_done", d, bad_done, 0);
      run_op(d, 1, 4'b0001, 2'b00, 32'h0f0, 32'h00f);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter: LAT, default 1, ALU settle cycles in EXEC before capture; legal 1..4.
REQ-002 Parameter: IDLE_GIN, default 4'b1000, ALU control code driven when no operation is in flight.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req0 / req1  input  1 each  requester N operation request; held high until gntN.
REQ-006 Port: gin0 / gin1  input  4 each  ALU control code from requester N.
REQ-007 Port: zc0 / zc1  input  2 each  zero-condition select from requester N.
REQ-008 Port: a0, b0 / a1, b1  input  32 each  operands from requester N.
REQ-009 Port: gnt0 / gnt1  output  1 each  one-cycle pulse: requester N accepted, operands latched.
REQ-010 Port: done0 / done1  output  1 each  one-cycle pulse: result for requester N valid.
REQ-011 Port: res  output  32  registered result; zout  output  1  registered zero flag.
REQ-012 Port: busy  output  1  high in EXEC and DONE.
REQ-013 Port: alu_a, alu_b  output  32; alu_gin  output  4; alu_zcond  output  2  drive the shared ALU.
REQ-014 Port: alu_sum  input  32; alu_zout  input  1  shared ALU results.

Function
REQ-015 FSM states IDLE, EXEC, DONE shall be implemented.
REQ-016 IDLE, any reqN high: winner's gin/zc/a/b latched, gntN high next cycle, state -> EXEC, counter loaded LAT-1.
REQ-017 EXEC: alu_* outputs driven from latched fields; counter decrements each cycle; at counter==0 alu_sum/alu_zout captured into res/zout, state -> DONE.
REQ-018 DONE: doneN high for the served requester for exactly one cycle; state -> IDLE next cycle.
REQ-019 Latency: req sampled at edge t -> gnt at t+1 -> done at t+1+LAT; next grant earliest at t+3+LAT.
REQ-020 IDLE and DONE: alu_gin = IDLE_GIN, alu_a = alu_b = 0, alu_zcond = 0.
REQ-021 Requests arriving in EXEC/DONE shall be ignored until IDLE; a req still high in IDLE is a new request.
REQ-022 gnt0 and gnt1 shall never be high together; likewise done0/done1.
REQ-023 res and zout shall hold their value between captures.
REQ-024 Latched operands shall not change during EXEC regardless of requester inputs.

Reset
REQ-025 reset high at an edge: state IDLE, counter 0, res 0, zout 0, gnt*/done*/busy 0, last-served pointer = 1.
REQ-026 reset in EXEC or DONE shall abort the operation; no done pulse issued for it.
REQ-027 reset has priority over every other event in the same cycle.

Configuration
REQ-028 Macro ALU_SHARE_RR_EN defined: round-robin; on simultaneous requests the requester not last served wins; pointer updates at each grant.
REQ-029 ALU_SHARE_RR_EN undefined: fixed priority, req0 always wins simultaneous requests; pointer logic absent.

Verification
REQ-030 reset, req0 gin0=0010 a0=5 b0=7, LAT=1 -> gnt0 at t+1, done0 at t+2, res=12, zout=0.
REQ-031 req1 gin1=0110 zc1=01 a1=9 b1=9 -> res=0; zout taken from alu_zout, matches ALU bne convention.
REQ-032 req0 and req1 held together, RR_EN defined -> grants alternate 0,1,0,1; undefined -> gnt0 only while req0 high.
REQ-033 LAT=3, req0 ADD a0=1 b0=1 -> done0 exactly 4 cycles after req sampled; a0 changed to 100 during EXEC -> res=2.
REQ-034 reset asserted one cycle into EXEC -> no done pulse, res=0, busy=0 next cycle, alu_gin=1000.
REQ-035 idle with no requests for 10 cycles -> alu_gin=1000, busy=0, res unchanged from prior result.
